// File: rtl/uart_tx_mmio.sv
// uart_tx_mmio: store-driven UART transmitter with byte FIFO and status word.
// Define UART_TX_PARITY_EN for 8E1 frames (even parity); default is 8N1.
module uart_tx_mmio #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        write_enable,
  input  logic [3:0]  mem_mask_write,
  input  logic        addr_write,
  input  logic [31:0] data_in,
  input  logic        read_enable,
  input  logic        addr_read,
  output logic [31:0] data_out,
  output logic        tx
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] C_RELOAD = CW'(CLKS_PER_BIT - 1);
  localparam logic [AW:0]   C_DEPTH  = (AW+1)'(FIFO_DEPTH);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_STOP   = 3'd3;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd4;
`endif

  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [AW:0]   r_level;
  logic          r_ovf;
  logic [2:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_idx;
  logic [7:0]    r_shift;
  logic          r_tx;
  logic [31:0]   r_data_out;
`ifdef UART_TX_PARITY_EN
  logic          r_par;
`endif

  logic        w_full;
  logic        w_empty;
  logic        w_push_req;
  logic        w_push;
  logic        w_clr;
  logic        w_tick;
  logic        w_pop;
  logic [31:0] w_status;
  logic        w_unused;

  assign w_full     = (r_level == C_DEPTH);
  assign w_empty    = (r_level == '0);
  assign w_push_req = write_enable && !addr_write && mem_mask_write[0];
  assign w_push     = w_push_req && !w_full;
  assign w_clr      = write_enable && addr_write && mem_mask_write[0]
                      && data_in[3];
  assign w_tick     = (r_cnt == '0);
  assign w_pop      = !w_empty && ((r_state == S_IDLE) ||
                      (r_state == S_STOP && w_tick));
  assign w_unused   = ^{data_in[31:8], mem_mask_write[3:1]};

  assign data_out = r_data_out;
  assign tx       = r_tx;

  // Assemble the status word from the current registered state.
  always_comb begin
    w_status             = '0;
    w_status[0]          = w_full;
    w_status[1]          = w_empty;
    w_status[2]          = (r_state != S_IDLE);
    w_status[3]          = r_ovf;
    w_status[AW+8:8]     = r_level;
  end

  // FIFO storage; contents need no reset since level gates every read.
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem[r_wr] <= data_in[7:0];
    end
  end

  // FIFO pointers and occupancy; push and pop together keep level.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  // Sticky overflow: set by a dropped push, cleared through CTRL.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_ovf <= 1'b0;
    end else if (w_push_req && w_full) begin
      r_ovf <= 1'b1;
    end else if (w_clr) begin
      r_ovf <= 1'b0;
    end
  end

  // Registered read port; holds its value when not reading.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_data_out <= '0;
    end else if (read_enable) begin
      r_data_out <= addr_read ? w_status : 32'd0;
    end
  end

  // Serializer: start, eight data bits LSB first, optional parity, stop.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
`ifdef UART_TX_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          r_tx <= 1'b1;
          if (w_pop) begin
            r_shift <= r_mem[r_rd];
`ifdef UART_TX_PARITY_EN
            r_par   <= ^r_mem[r_rd];
`endif
            r_cnt   <= C_RELOAD;
            r_tx    <= 1'b0;
            r_state <= S_START;
          end
        end
        S_START: begin
          if (w_tick) begin
            r_cnt   <= C_RELOAD;
            r_tx    <= r_shift[0];
            r_idx   <= '0;
            r_state <= S_DATA;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_DATA: begin
          if (w_tick) begin
            r_cnt <= C_RELOAD;
            if (r_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              r_tx    <= r_par;
              r_state <= S_PARITY;
`else
              r_tx    <= 1'b1;
              r_state <= S_STOP;
`endif
            end else begin
              r_shift <= r_shift >> 1;
              r_tx    <= r_shift[1];
              r_idx   <= r_idx + 3'd1;
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          if (w_tick) begin
            r_cnt   <= C_RELOAD;
            r_tx    <= 1'b1;
            r_state <= S_STOP;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
`endif
        S_STOP: begin
          if (w_tick) begin
            if (w_pop) begin
              r_shift <= r_mem[r_rd];
`ifdef UART_TX_PARITY_EN
              r_par   <= ^r_mem[r_rd];
`endif
              r_cnt   <= C_RELOAD;
              r_tx    <= 1'b0;
              r_state <= S_START;
            end else begin
              r_tx    <= 1'b1;
              r_state <= S_IDLE;
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: begin
          r_tx    <= 1'b1;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// tb_uart_tx_mmio: randomized and directed bench for uart_tx_mmio.
// A line monitor decodes tx into frames for comparison with a byte model.
module tb_uart_tx_mmio;
  localparam int CPB   = 4;
  localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FRAME = NB * CPB;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        write_enable = 1'b0;
  logic [3:0]  mem_mask_write = 4'd0;
  logic        addr_write = 1'b0;
  logic [31:0] data_in = 32'd0;
  logic        read_enable = 1'b0;
  logic        addr_read = 1'b0;
  logic [31:0] data_out;
  logic        tx;

  uart_tx_mmio #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .write_enable(write_enable),
    .mem_mask_write(mem_mask_write), .addr_write(addr_write),
    .data_in(data_in), .read_enable(read_enable),
    .addr_read(addr_read), .data_out(data_out), .tx(tx)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;
  int g_n0;

  typedef struct {
    logic [7:0] data;
    int         start;
    logic       good;
  } frame_t;
  frame_t rx_q[$];

  // Line monitor: frames start on a low level, every bit must be stable.
  bit          m_act = 1'b0;
  int          m_t;
  int          m_start;
  logic        m_good;
  logic        m_rst;
  logic [NB-1:0] m_bits;
  frame_t      m_f;
  always @(posedge clock) begin
    m_rst = reset;
    #1;
    if (m_rst) begin
      m_act = 1'b0;
    end else begin
      if (!m_act) begin
        if (tx === 1'b0) begin
          m_act = 1'b1; m_t = 0; m_start = cyc; m_good = 1'b1;
        end
      end else begin
        m_t = m_t + 1;
      end
      if (m_act) begin
        if (m_t % CPB == 0) m_bits[m_t/CPB] = tx;
        else if (tx !== m_bits[m_t/CPB]) m_good = 1'b0;
        if (m_t == FRAME - 1) begin
          if (m_bits[0] !== 1'b0 || m_bits[NB-1] !== 1'b1) m_good = 1'b0;
`ifdef UART_TX_PARITY_EN
          if (m_bits[9] !== ^m_bits[8:1]) m_good = 1'b0;
`endif
          m_f.data = m_bits[8:1];
          m_f.start = m_start;
          m_f.good = m_good;
          rx_q.push_back(m_f);
          m_act = 1'b0;
        end
      end
    end
  end

  function automatic logic [31:0] status_word(int lvl, bit ovf, bit busy);
    logic [31:0] s;
    s = 32'(lvl) << 8;
    s[3] = ovf;
    s[2] = busy;
    s[1] = (lvl == 0);
    s[0] = (lvl == DEPTH);
    return s;
  endfunction

  function automatic logic [NB-1:0] frame_bits(logic [7:0] b);
    logic [NB-1:0] f;
    f = '1;
    f[0] = 1'b0;
    f[8:1] = b;
`ifdef UART_TX_PARITY_EN
    f[9] = ^b;
`endif
    return f;
  endfunction

  task automatic wr(input logic a, input logic [3:0] m, input logic [31:0] d);
    write_enable = 1'b1; addr_write = a; mem_mask_write = m; data_in = d;
  endtask

  task automatic wr_off();
    write_enable = 1'b0; addr_write = 1'b0;
    mem_mask_write = 4'd0; data_in = 32'd0;
  endtask

  task automatic rd(input logic a, output logic [31:0] v);
    read_enable = 1'b1; addr_read = a;
    @(negedge clock);
    v = data_out;
    read_enable = 1'b0; addr_read = 1'b0;
  endtask

  task automatic wait_frames(input int n, input int budget, output bit ok);
    for (int i = 0; i < budget && rx_q.size() < n; i++) @(negedge clock);
    ok = (rx_q.size() >= n);
  endtask

  task automatic watch_high(input int n, output int lows);
    lows = 0;
    repeat (n) begin
      @(negedge clock);
      if (tx !== 1'b1) lows++;
    end
  endtask

  task automatic test_reset();
    logic [31:0] v;
    reset = 1'b1;
    repeat (3) @(negedge clock);
    checks++;
    if (tx !== 1'b1) begin
      errors++; $display("FAIL reset_tx: got %b expected 1", tx);
    end
    checks++;
    if (data_out !== 32'd0) begin
      errors++; $display("FAIL reset_data_out: got %h expected 0", data_out);
    end
    reset = 1'b0;
    rd(1'b1, v);
    checks++;
    if (v !== status_word(0, 0, 0)) begin
      errors++; $display("FAIL reset_status: got %h expected %h", v, status_word(0, 0, 0));
    end
  endtask

  task automatic test_single();
    logic [NB-1:0] fb;
    logic [31:0] v;
    int n;
    rx_q.delete();
    fb = frame_bits(8'hA5);
    @(negedge clock);
    wr(1'b0, 4'b0001, 32'h0000_00A5);
    @(negedge clock);
    wr_off();
    n = cyc;
    checks++;
    if (tx !== 1'b1) begin
      errors++; $display("FAIL single_cycle1: got %b expected 1", tx);
    end
    for (int c = 2; c <= FRAME + 1; c++) begin
      @(negedge clock);
      checks++;
      if (tx !== fb[(c-2)/CPB]) begin
        errors++;
        $display("FAIL single_bit cycle %0d: got %b expected %b", c, tx, fb[(c-2)/CPB]);
      end
    end
    rd(1'b1, v);
    checks++;
    if (v !== status_word(0, 0, 1)) begin
      errors++; $display("FAIL single_busy_last: got %h expected %h", v, status_word(0, 0, 1));
    end
    rd(1'b1, v);
    checks++;
    if (v !== status_word(0, 0, 0)) begin
      errors++; $display("FAIL single_idle: got %h expected %h", v, status_word(0, 0, 0));
    end
    checks++;
    if (rx_q.size() != 1) begin
      errors++; $display("FAIL single_frames: got %0d expected 1", rx_q.size());
    end else begin
      checks++;
      if (rx_q[0].data !== 8'hA5 || rx_q[0].good !== 1'b1 || rx_q[0].start != n + 1) begin
        errors++;
        $display("FAIL single_frame: got %h/%b/%0d expected a5/1/%0d",
                 rx_q[0].data, rx_q[0].good, rx_q[0].start, n + 1);
      end
    end
  endtask

  task automatic test_mask_ignored();
    logic [31:0] v;
    int lows;
    rx_q.delete();
    @(negedge clock);
    wr(1'b0, 4'b0010, 32'h0000_00FF);
    @(negedge clock);
    wr_off();
    watch_high(2 * FRAME, lows);
    checks++;
    if (lows != 0) begin
      errors++; $display("FAIL mask_tx_low: got %0d low cycles expected 0", lows);
    end
    rd(1'b1, v);
    checks++;
    if (v !== 32'h0000_0002) begin
      errors++; $display("FAIL mask_status: got %h expected 00000002", v);
    end
    rd(1'b0, v);
    checks++;
    if (v !== 32'd0) begin
      errors++; $display("FAIL txdata_read: got %h expected 0", v);
    end
    checks++;
    if (rx_q.size() != 0) begin
      errors++; $display("FAIL mask_frames: got %0d expected 0", rx_q.size());
    end
  endtask

  task automatic test_overflow();
    logic [31:0] v;
    rx_q.delete();
    for (int i = 1; i <= 6; i++) begin
      @(negedge clock);
      if (i == 1) g_n0 = cyc + 1;
      wr(1'b0, 4'b0001, 32'(i));
    end
    @(negedge clock);
    wr_off();
    rd(1'b1, v);
    checks++;
    if (v !== status_word(DEPTH, 1, 1)) begin
      errors++; $display("FAIL overflow_status: got %h expected %h", v, status_word(DEPTH, 1, 1));
    end
  endtask

  task automatic test_ctrl_clear();
    logic [31:0] v;
    wr(1'b1, 4'b1110, 32'h0000_0008);
    @(negedge clock);
    wr_off();
    rd(1'b1, v);
    checks++;
    if (v !== status_word(DEPTH, 1, 1)) begin
      errors++; $display("FAIL ctrl_nomask: got %h expected %h", v, status_word(DEPTH, 1, 1));
    end
    wr(1'b1, 4'b0001, 32'hFFFF_FFF7);
    @(negedge clock);
    wr_off();
    rd(1'b1, v);
    checks++;
    if (v !== status_word(DEPTH, 1, 1)) begin
      errors++; $display("FAIL ctrl_nobit3: got %h expected %h", v, status_word(DEPTH, 1, 1));
    end
    wr(1'b1, 4'b0001, 32'h0000_0008);
    @(negedge clock);
    wr_off();
    rd(1'b1, v);
    checks++;
    if (v !== status_word(DEPTH, 0, 1)) begin
      errors++; $display("FAIL ctrl_clear: got %h expected %h", v, status_word(DEPTH, 0, 1));
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] v;
    bit ok;
    wait_frames(5, 6 * FRAME, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL b2b_timeout: got %0d frames expected 5", rx_q.size());
    end
    for (int i = 0; i < 5 && i < rx_q.size(); i++) begin
      checks++;
      if (rx_q[i].data !== 8'(i + 1) || rx_q[i].good !== 1'b1 ||
          rx_q[i].start != g_n0 + 1 + i * FRAME) begin
        errors++;
        $display("FAIL b2b_frame%0d: got %h/%b/%0d expected %h/1/%0d", i,
                 rx_q[i].data, rx_q[i].good, rx_q[i].start, 8'(i + 1),
                 g_n0 + 1 + i * FRAME);
      end
    end
    repeat (2) @(negedge clock);
    rd(1'b1, v);
    checks++;
    if (v !== status_word(0, 0, 0) || rx_q.size() != 5) begin
      errors++; $display("FAIL b2b_end: got %h/%0d expected %h/5", v, rx_q.size(), status_word(0, 0, 0));
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] v;
    logic [7:0] bytes [3];
    int lows;
    bytes[0] = 8'h3C; bytes[1] = 8'hC3; bytes[2] = 8'h99;
    rx_q.delete();
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      if (i == 0) g_n0 = cyc + 1;
      wr(1'b0, 4'b0001, {24'd0, bytes[i]});
    end
    @(negedge clock);
    wr_off();
    while (cyc < g_n0 + 1 + FRAME + 2 * CPB + 1) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    checks++;
    if (tx !== 1'b1) begin
      errors++; $display("FAIL rstmid_tx: got %b expected 1", tx);
    end
    rd(1'b1, v);
    checks++;
    if (v !== 32'h0000_0002) begin
      errors++; $display("FAIL rstmid_status: got %h expected 00000002", v);
    end
    watch_high(3 * FRAME, lows);
    checks++;
    if (lows != 0) begin
      errors++; $display("FAIL rstmid_tx_low: got %0d low cycles expected 0", lows);
    end
    checks++;
    if (rx_q.size() != 1) begin
      errors++; $display("FAIL rstmid_frames: got %0d expected 1", rx_q.size());
    end else begin
      checks++;
      if (rx_q[0].data !== 8'h3C || rx_q[0].good !== 1'b1) begin
        errors++; $display("FAIL rstmid_first: got %h/%b expected 3c/1", rx_q[0].data, rx_q[0].good);
      end
    end
  endtask

  task automatic test_stop_push();
    logic [31:0] v;
    logic [7:0] exp [3];
    bit ok;
    exp[0] = 8'h5A; exp[1] = 8'hA7; exp[2] = 8'hE1;
    rx_q.delete();
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      if (i == 0) g_n0 = cyc + 1;
      wr(1'b0, 4'b0001, {24'd0, exp[i]});
    end
    @(negedge clock);
    wr_off();
    while (cyc < g_n0 + 10) @(negedge clock);
    rd(1'b1, v);
    checks++;
    if (v !== status_word(1, 0, 1)) begin
      errors++; $display("FAIL stoppush_pre: got %h expected %h", v, status_word(1, 0, 1));
    end
    while (cyc < g_n0 + FRAME) @(negedge clock);
    wr(1'b0, 4'b0001, {24'd0, exp[2]});
    @(negedge clock);
    wr_off();
    rd(1'b1, v);
    checks++;
    if (v !== status_word(1, 0, 1)) begin
      errors++; $display("FAIL stoppush_level: got %h expected %h", v, status_word(1, 0, 1));
    end
    wait_frames(3, 4 * FRAME, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL stoppush_timeout: got %0d frames expected 3", rx_q.size());
    end
    for (int i = 0; i < 3 && i < rx_q.size(); i++) begin
      checks++;
      if (rx_q[i].data !== exp[i] || rx_q[i].good !== 1'b1 ||
          rx_q[i].start != g_n0 + 1 + i * FRAME) begin
        errors++;
        $display("FAIL stoppush_frame%0d: got %h/%b/%0d expected %h/1/%0d", i,
                 rx_q[i].data, rx_q[i].good, rx_q[i].start, exp[i],
                 g_n0 + 1 + i * FRAME);
      end
    end
    repeat (2) @(negedge clock);
  endtask

  task automatic test_random();
    logic [31:0] v;
    logic [31:0] r;
    logic [7:0] b;
    logic [3:0] m;
    logic [7:0] exp [$];
    int len, first, acc, n0, lvl, pre;
    bit ovf, popped, ok;
    for (int it = 0; it < 10; it++) begin
      rx_q.delete();
      exp.delete();
      len = $urandom_range(1, 6);
      first = -1; acc = 0; ovf = 1'b0;
      for (int k = 0; k < len; k++) begin
        @(negedge clock);
        if (k == 0) n0 = cyc + 1;
        b = 8'($urandom);
        r = $urandom;
        m = 4'($urandom_range(0, 15));
        if ($urandom_range(0, 3) != 0) m[0] = 1'b1;
        wr(1'b0, m, {r[31:8], b});
        if (m[0]) begin
          pre = acc - ((first >= 0 && first + 1 <= k - 1) ? 1 : 0);
          if (pre < DEPTH) begin
            exp.push_back(b);
            acc++;
            if (first < 0) first = k;
          end else begin
            ovf = 1'b1;
          end
        end
      end
      @(negedge clock);
      wr_off();
      popped = (first >= 0 && first + 1 <= len - 1);
      lvl = acc - (popped ? 1 : 0);
      rd(1'b1, v);
      checks++;
      if (v !== status_word(lvl, ovf, popped)) begin
        errors++;
        $display("FAIL rand%0d_status: got %h expected %h", it, v, status_word(lvl, ovf, popped));
      end
      wait_frames(exp.size(), (exp.size() + 1) * FRAME, ok);
      repeat (2) @(negedge clock);
      checks++;
      if (!ok || rx_q.size() != exp.size()) begin
        errors++;
        $display("FAIL rand%0d_count: got %0d frames expected %0d", it, rx_q.size(), exp.size());
      end
      for (int i = 0; i < exp.size() && i < rx_q.size(); i++) begin
        checks++;
        if (rx_q[i].data !== exp[i] || rx_q[i].good !== 1'b1 ||
            rx_q[i].start != n0 + first + 1 + i * FRAME) begin
          errors++;
          $display("FAIL rand%0d_frame%0d: got %h/%b/%0d expected %h/1/%0d", it, i,
                   rx_q[i].data, rx_q[i].good, rx_q[i].start, exp[i],
                   n0 + first + 1 + i * FRAME);
        end
      end
      wr(1'b1, 4'b0001, 32'h0000_0008);
      @(negedge clock);
      wr_off();
      rd(1'b1, v);
      checks++;
      if (v !== status_word(0, 0, 0)) begin
        errors++; $display("FAIL rand%0d_idle: got %h expected %h", it, v, status_word(0, 0, 0));
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_mask_ignored();
    test_overflow();
    test_ctrl_clear();
    test_back_to_back();
    test_reset_mid();
    test_stop_push();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule

// File: doc/uart_tx_mmio.md
# uart_tx_mmio

Memory-mapped UART transmitter attached to the processor's data-store path, next to the BRAM on the same address-decoded bus. A processor store to the TX data word enqueues one byte into an internal FIFO, and a baud-rate FSM serializes the FIFO contents onto a single 8N1 line. A registered status word lets firmware poll FIFO level, busy and overflow before issuing further stores.

## Interface
- CLKS_PER_BIT, default 868: clock cycles per serial bit (100 MHz / 115200). Must be ≥ 2.
- FIFO_DEPTH, default 16: byte entries. Must be a power of two, ≥ 2.
- clock  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- write_enable  in  1  bus write strobe, sampled each cycle.
- mem_mask_write  in  4  byte-lane write mask; bit0 = data_in[7:0].
- addr_write  in  1  word select: 0 = TXDATA, 1 = CTRL.
- data_in  in  32  store data.
- read_enable  in  1  bus read strobe.
- addr_read  in  1  word select: 0 = TXDATA (reads 0), 1 = STATUS.
- data_out  out  32  registered read data.
- tx  out  1  serial line; idles high.

## Operation
- Push: write_enable && addr_write==0 && mem_mask_write[0] pushes data_in[7:0]. Writes with mask[0]=0 are ignored.
- Full flag is taken from the pre-edge state. A push when full is dropped and sets overflow, even if a pop happens in the same cycle.
- CTRL write: write_enable && addr_write==1 && mask[0] && data_in[3] clears overflow. A push to TXDATA cannot occur in the same cycle, because only one address is written.
- STATUS word:
  - [0] full
  - [1] empty
  - [2] busy (FSM not IDLE)
  - [3] overflow (sticky)
  - [log2(FIFO_DEPTH)+8:8] level, 0..FIFO_DEPTH
  - all other bits 0
- Read: when read_enable is high, data_out is loaded on the edge; otherwise data_out holds its value.
- FIFO: circular buffer with read/write pointers of log2(FIFO_DEPTH) bits that wrap modulo the depth, plus a level counter of log2(FIFO_DEPTH)+1 bits. A simultaneous push and pop leaves the level unchanged.
- FSM states:
  - IDLE: tx=1. If the FIFO is non-empty, pop into the shift register, load the baud counter with CLKS_PER_BIT-1, and go to START.
  - START: tx=0 for one bit period, then go to DATA with bit index 0.
  - DATA: tx = shift[0], LSB first. Shift right on each bit boundary. After bit 7 go to STOP.
  - STOP: tx=1 for one bit period. On expiry, if the FIFO is non-empty, pop and go directly to START (no idle gap); otherwise go to IDLE.
- Baud counter: counts down from CLKS_PER_BIT-1; the bit boundary is at count==0, which reloads the counter. Width is $clog2(CLKS_PER_BIT).
- Reset values: tx=1, data_out=0, FIFO empty (level 0, pointers 0), overflow=0, state IDLE, counter 0. Reset mid-frame aborts the frame (tx high on the next cycle) and flushes the FIFO.

## Timing
- A push sampled at edge N makes level=1 after edge N.
- IDLE pops at edge N+1; tx falls after edge N+1 (2-cycle push-to-start latency).
- Each bit lasts exactly CLKS_PER_BIT cycles.
- Frame length: 10×CLKS_PER_BIT cycles (11× with parity).
- Back-to-back frames have zero idle cycles between the stop bit and the next start bit.
- Read latency is 1 cycle; STATUS reflects state after the previous edge.
- busy rises the same edge tx falls. It falls the edge the STOP bit ends with the FIFO empty.

## Configuration
- UART_TX_PARITY_EN defined: a PARITY state is inserted between DATA and STOP. It drives the even-parity bit (XOR of the 8 data bits) for one bit period; frames are 8E1, 11 bits.
- UART_TX_PARITY_EN undefined: no PARITY state; frames are 8N1, 10 bits.

## Test plan
All scenarios use CLKS_PER_BIT=4 and FIFO_DEPTH=4.
- Write 0x000000A5 to TXDATA with mask 0001. Required:
  - tx low for cycles 2–5 after the write;
  - then data bits 1,0,1,0,0,1,0,1 (4 cycles each);
  - then high for the stop bit;
  - busy=0 from cycle 42 onward.
  - With UART_TX_PARITY_EN: parity bit 0 before stop, busy=0 from cycle 46.
- Write 0x000000FF with mask 0010. Required: no push; STATUS reads 0x00000002; tx stays high.
- Six consecutive pushes 0x01..0x06 while idle. Required:
  - first pop leaves room, so 5 bytes are accepted and 0x06 is dropped;
  - STATUS[3]=1;
  - 0x01..0x05 are transmitted back-to-back with no idle gap, 200 cycles total.
- Write CTRL with data_in=0x8 after the overflow. Required: STATUS[3]=0; other bits unchanged.
- Assert reset for 1 cycle mid-DATA of the second queued byte. Required:
  - tx=1 next cycle;
  - STATUS=0x00000002;
  - no further frame is transmitted.
- Push a byte in the same cycle STOP expires with 1 entry queued. Required:
  - immediate START of the queued byte;
  - level stays 1;
  - the new byte follows as the next frame.
